// File: rtl/mul_32bit_seq_if.sv
// Request/response bundle between the execute-stage control unit and the
// sequential multiplier: operands and start in, busy/done and product out.
interface mul_32bit_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  modport master (
    output start, in1, in2,
    input  busy, done, prod_hi, prod_lo
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, prod_hi, prod_lo
  );
endinterface

// File: rtl/mul_32bit_seq.sv
// Unsigned shift-add multiplier: fixed WIDTH iterations per product, with a
// start/busy/done handshake so the control unit can stall during a multiply.
module mul_32bit_seq #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  mul_32bit_seq_if.slave mul_if
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH:0]   sum_s;

  // One WIDTH+1 bit add keeps the carry that the right shift moves into hi.
  assign sum_s = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = done_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (mul_if.start) begin
          mcand_d = mul_if.in1;
          hi_d    = {WIDTH{1'b0}};
          lo_d    = mul_if.in2;
          count_d = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        hi_d    = sum_s[WIDTH:1];
        lo_d    = {sum_s[0], lo_q[WIDTH-1:1]};
        count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        if (count_q == LAST_ITER) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_BUSY;
        end
      end
      S_DONE: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mcand_q <= {WIDTH{1'b0}};
      hi_q    <= {WIDTH{1'b0}};
      lo_q    <= {WIDTH{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_d;
    end
  end

  assign mul_if.busy    = busy_q;
  assign mul_if.done    = done_q;
  assign mul_if.prod_hi = hi_q;
  assign mul_if.prod_lo = lo_q;

endmodule

// File: tb/tb_mul_32bit_seq.sv
// Directed-vector bench for mul_32bit_seq: handshake timing, products,
// ignored re-starts, mid-run reset and held-start spacing.
module tb_mul_32bit_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   err_cnt = 0;
  int   chk_cnt = 0;

  mul_32bit_seq_if #(.WIDTH(32)) bus ();

  mul_32bit_seq #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .mul_if (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one multiply; repulse>0 raises start with 2x2 on the inputs at that edge.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input int repulse);
    int bad_busy;
    int early_done;
    bus.start = 1'b1;
    bus.in1   = a;
    bus.in2   = b;
    step();
    bus.start = 1'b0;
    bus.in1   = ~a;
    bus.in2   = ~b;
    chk({tag, "_busy_e0"}, {63'd0, bus.busy}, 64'd1);
    bad_busy   = 0;
    early_done = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == repulse) begin
        bus.start = 1'b1;
        bus.in1   = 32'd2;
        bus.in2   = 32'd2;
      end else begin
        bus.start = 1'b0;
      end
      step();
      if (k < 32) begin
        if (bus.busy !== 1'b1) bad_busy++;
        if (bus.done !== 1'b0) early_done++;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_busy_run"}, 64'(bad_busy), 64'd0);
    chk({tag, "_early_done"}, 64'(early_done), 64'd0);
    chk({tag, "_busy_e32"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_done_e32"}, {63'd0, bus.done}, 64'd1);
    chk({tag, "_prod"}, {bus.prod_hi, bus.prod_lo}, exp);
    step();
    chk({tag, "_done_e33"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_prod_hold"}, {bus.prod_hi, bus.prod_lo}, exp);
  endtask

  initial begin
    int stray;
    int first_done;
    int second_done;
    logic [63:0] second_prod;
    bus.start = 1'b0;
    bus.in1   = 32'd0;
    bus.in2   = 32'd0;
    step();
    step();
    rst = 1'b0;
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);

    do_mul("m3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F, 0);
    do_mul("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0);
    do_mul("maaax2", 32'hAAAA_AAAA, 32'd2, 64'h0000_0001_5555_5554, 0);
    do_mul("m64k", 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 0);
    do_mul("m7x9", 32'd7, 32'd9, 64'd63, 10);
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
    end
    chk("m7x9_not_queued", 64'(stray), 64'd0);

    // Abort a run with reset asserted at E15.
    bus.start = 1'b1;
    bus.in1   = 32'hFFFF_FFFF;
    bus.in2   = 32'hFFFF_FFFF;
    step();
    bus.start = 1'b0;
    for (int k = 1; k <= 14; k++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_done", {63'd0, bus.done}, 64'd0);
    chk("abort_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) stray++;
    end
    chk("abort_no_done", 64'(stray), 64'd0);

    // Reset and start on the same edge: start is dropped.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.in1   = 32'd9;
    bus.in2   = 32'd9;
    step();
    rst       = 1'b0;
    bus.start = 1'b0;
    step();
    chk("rst_start_busy", {63'd0, bus.busy}, 64'd0);

    do_mul("m6x7", 32'd6, 32'd7, 64'd42, 0);

    // Held start: accepts every 34 edges, dones at edge 32 and 66.
    bus.start   = 1'b1;
    bus.in1     = 32'd3;
    bus.in2     = 32'd5;
    first_done  = -1;
    second_done = -1;
    second_prod = 64'd0;
    for (int e = 0; e < 80; e++) begin
      step();
      if (bus.done === 1'b1) begin
        if (first_done < 0) begin
          first_done = e;
        end else if (second_done < 0) begin
          second_done = e;
          second_prod = {bus.prod_hi, bus.prod_lo};
        end
      end
    end
    bus.start = 1'b0;
    chk("held_first_done", 64'(first_done), 64'd32);
    chk("held_second_done", 64'(second_done), 64'd66);
    chk("held_second_prod", second_prod, 64'd15);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
